fetch_hazard_controller: RTL and testbench

//  Sequences the fetch stage (PC muxes + program memory): drives stall, stall_pm,
//  pc_mux_sel and jmp_loc. Detects load-use hazards between ID and EX, redirects on

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/fetch_hazard_controller.sv | 145 ++++++++++++++
 tb/tb_fetch_hazard_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage hazard/redirect controller.
package fetch_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_REG_AW  = 3;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned STALL_CNT_W = 16;
    localparam logic [31:0] NOP_WORD    = 32'b0;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StLstall = 2'b01,
        StFlush  = 2'b10,
        StHalt   = 2'b11
    } ctrl_state_e;

    // Counter preload for a multi-cycle state; the entry cycle itself is the first one.
    function automatic logic [CNT_W-1:0] init_cnt(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID and EX stages.
module load_use_detect
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // Register 0 is hardwired zero, so a load into it never creates a dependency.
    assign hazard = ex_is_load && (ex_rd != '0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/fetch_hazard_controller.sv
// Fetch-stage sequencer: load-use stalls, taken-branch redirect/flush, debug halt,
// and a saturating count of stalled cycles.
module fetch_hazard_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned REG_AW         = DEF_REG_AW,
    parameter int unsigned LOAD_STALL_CYC = 1,
    parameter int unsigned FLUSH_CYC      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   ex_is_load,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   br_taken,
    input  logic [ADDR_W-1:0]      br_target,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic                   stall,
    output logic                   stall_pm,
    output logic                   pc_mux_sel,
    output logic [ADDR_W-1:0]      jmp_loc,
    output logic                   flush_id,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] LOAD_INIT  = init_cnt(LOAD_STALL_CYC);
    localparam logic [CNT_W-1:0] FLUSH_INIT = init_cnt(FLUSH_CYC);

    ctrl_state_e            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic              w_hazard;
    logic              w_stall;
    logic              w_stall_pm;
    logic              w_pc_mux_sel;
    logic [ADDR_W-1:0] w_jmp_loc;
    logic              w_flush_id;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .hazard      (w_hazard)
    );

    always_comb begin
        w_stall      = 1'b0;
        w_stall_pm   = 1'b0;
        w_pc_mux_sel = 1'b0;
        w_jmp_loc    = '0;
        w_flush_id   = 1'b0;
        case (r_state)
            StRun: begin
                // A taken branch makes the ID instruction wrong-path, so its hazard is moot.
                if (br_taken) begin
                    w_pc_mux_sel = 1'b1;
                    w_jmp_loc    = br_target;
                    w_flush_id   = 1'b1;
                end else if (w_hazard) begin
                    w_stall    = 1'b1;
                    w_stall_pm = 1'b1;
                    w_flush_id = 1'b1;
                end
            end
            StLstall, StHalt: begin
                w_stall    = 1'b1;
                w_stall_pm = 1'b1;
                w_flush_id = 1'b1;
            end
            StFlush: begin
                w_flush_id = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StRun: begin
                    if (br_taken) begin
                        if (FLUSH_CYC > 1) begin
                            r_state <= StFlush;
                            r_cnt   <= FLUSH_INIT;
                        end
                    end else if (w_hazard) begin
                        if (LOAD_STALL_CYC > 1) begin
                            r_state <= StLstall;
                            r_cnt   <= LOAD_INIT;
                        end
                    end else if (halt_req) begin
                        r_state <= StHalt;
                    end
                end
                StLstall, StFlush: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= StRun;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StHalt: begin
                    if (resume) begin
                        r_state <= StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    // Fetch consumes these in the same cycle; hold them quiet while reset is low.
    assign stall      = reset && w_stall;
    assign stall_pm   = reset && w_stall_pm;
    assign pc_mux_sel = reset && w_pc_mux_sel;
    assign flush_id   = reset && w_flush_id;
    assign jmp_loc    = reset ? w_jmp_loc : '0;
    assign ctrl_state = reset ? r_state : StRun;
    assign stall_cnt  = reset ? r_stall_cnt : '0;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Directed bench for fetch_hazard_controller: per-cycle vector table plus reset,
// long-stall LSTALL and stall-counter saturation sequences.
module tb_fetch_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_is_load;
    logic        br_taken, halt_req, resume;
    logic [15:0] br_target;

    logic        a_stall, a_stall_pm, a_sel, a_flush;
    logic [15:0] a_jmp, a_cnt;
    logic [1:0]  a_state;
    logic        b_stall, b_stall_pm, b_sel, b_flush;
    logic [15:0] b_jmp, b_cnt;
    logic [1:0]  b_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_hazard_controller u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .stall       (a_stall),
        .stall_pm    (a_stall_pm),
        .pc_mux_sel  (a_sel),
        .jmp_loc     (a_jmp),
        .flush_id    (a_flush),
        .ctrl_state  (a_state),
        .stall_cnt   (a_cnt)
    );

    fetch_hazard_controller #(
        .LOAD_STALL_CYC (3)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .stall       (b_stall),
        .stall_pm    (b_stall_pm),
        .pc_mux_sel  (b_sel),
        .jmp_loc     (b_jmp),
        .flush_id    (b_flush),
        .ctrl_state  (b_state),
        .stall_cnt   (b_cnt)
    );

    typedef struct {
        string       name;
        logic        br;
        logic [15:0] tgt;
        logic        ld;
        logic [2:0]  rd, rs1, rs2;
        logic        u1, u2, halt, res;
        logic        e_stall, e_sel, e_flush;
        logic [15:0] e_jmp;
        logic [1:0]  e_state;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic br, input logic [15:0] tgt,
                       input logic ld, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic u1, input logic u2,
                       input logic halt, input logic res, input logic e_stall,
                       input logic e_sel, input logic e_flush, input logic [15:0] e_jmp,
                       input logic [1:0] e_state, input logic [15:0] e_cnt);
        vec_t v;
        v.name = name; v.br = br; v.tgt = tgt; v.ld = ld; v.rd = rd; v.rs1 = rs1;
        v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.halt = halt; v.res = res;
        v.e_stall = e_stall; v.e_sel = e_sel; v.e_flush = e_flush; v.e_jmp = e_jmp;
        v.e_state = e_state; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic br, input logic [15:0] tgt, input logic ld,
                         input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic u1, input logic u2, input logic halt, input logic res);
        br_taken = br; br_target = tgt; ex_is_load = ld; ex_rd = rd; id_rs1 = rs1;
        id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2; halt_req = halt; resume = res;
    endtask

    task automatic idle();
        drive(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_a(input string tag, input logic st, input logic sel, input logic fl,
                         input logic [15:0] jmp, input logic [1:0] state,
                         input logic [15:0] cnt);
        chk({tag, " stall"},      a_stall, st);
        chk({tag, " stall_pm"},   a_stall_pm, st);
        chk({tag, " pc_mux_sel"}, a_sel, sel);
        chk({tag, " flush_id"},   a_flush, fl);
        chk({tag, " jmp_loc"},    a_jmp, jmp);
        chk({tag, " ctrl_state"}, a_state, state);
        chk({tag, " stall_cnt"},  a_cnt, cnt);
    endtask

    task automatic chk_b(input string tag, input logic st, input logic sel, input logic fl,
                         input logic [15:0] jmp, input logic [1:0] state,
                         input logic [15:0] cnt);
        chk({tag, " stall"},      b_stall, st);
        chk({tag, " stall_pm"},   b_stall_pm, st);
        chk({tag, " pc_mux_sel"}, b_sel, sel);
        chk({tag, " flush_id"},   b_flush, fl);
        chk({tag, " jmp_loc"},    b_jmp, jmp);
        chk({tag, " ctrl_state"}, b_state, state);
        chk({tag, " stall_cnt"},  b_cnt, cnt);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        //   name          br tgt      ld rd rs1 rs2 u1 u2 hlt res | st sel fl jmp      state cnt
        add("idle",        0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd0);
        add("haz_rs1",     0, 16'h0,    1, 3, 3, 0, 1, 0, 0, 0,    1, 0, 1, 16'h0,    2'd0, 16'd0);
        add("after_haz",   0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd1);
        add("rd_zero",     0, 16'h0,    1, 0, 0, 0, 1, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd1);
        add("haz_rs2",     0, 16'h0,    1, 5, 5, 5, 0, 1, 0, 0,    1, 0, 1, 16'h0,    2'd0, 16'd1);
        add("not_load",    0, 16'h0,    0, 5, 5, 0, 1, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd2);
        add("unused_src",  0, 16'h0,    1, 4, 4, 2, 0, 1, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd2);
        add("branch",      1, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1, 1, 16'h0040, 2'd0, 16'd2);
        add("flush_ign",   1, 16'h1234, 1, 3, 3, 0, 1, 0, 0, 0,    0, 0, 1, 16'h0,    2'd2, 16'd2);
        add("post_flush",  0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd2);
        add("br_and_haz",  1, 16'hBEEF, 1, 3, 3, 0, 1, 0, 0, 0,    0, 1, 1, 16'hBEEF, 2'd0, 16'd2);
        add("flush2",      0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 16'h0,    2'd2, 16'd2);
        add("run2",        0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd2);
        add("halt_req",    0, 16'h0,    0, 0, 0, 0, 0, 0, 1, 0,    0, 0, 0, 16'h0,    2'd0, 16'd2);
        add("halt1",       0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 16'h0,    2'd3, 16'd2);
        add("halt2",       1, 16'h0077, 1, 3, 3, 0, 1, 0, 0, 0,    1, 0, 1, 16'h0,    2'd3, 16'd3);
        add("halt3",       0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 16'h0,    2'd3, 16'd4);
        add("halt4",       0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 1, 16'h0,    2'd3, 16'd5);
        add("halt5_res",   0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 1,    1, 0, 1, 16'h0,    2'd3, 16'd6);
        add("resumed",     0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd7);
        add("hreq_res",    0, 16'h0,    0, 0, 0, 0, 0, 0, 1, 1,    0, 0, 0, 16'h0,    2'd0, 16'd7);
        add("halt_both",   0, 16'h0,    0, 0, 0, 0, 0, 0, 1, 1,    1, 0, 1, 16'h0,    2'd3, 16'd7);
        add("run3",        0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd8);
        add("haz_vs_halt", 0, 16'h0,    1, 6, 6, 0, 1, 0, 1, 0,    1, 0, 1, 16'h0,    2'd0, 16'd8);
        add("run4",        0, 16'h0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 16'h0,    2'd0, 16'd9);

        // Outputs must stay quiet under reset even with active inputs.
        reset = 1'b0;
        drive(1, 16'h0040, 1, 3, 3, 3, 1, 1, 1, 0);
        #12;
        chk_a("reset_a", 0, 0, 0, 16'h0, 2'd0, 16'd0);
        chk_b("reset_b", 0, 0, 0, 16'h0, 2'd0, 16'd0);
        @(negedge clk);
        idle();
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].br, vecs[i].tgt, vecs[i].ld, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].u1, vecs[i].u2, vecs[i].halt, vecs[i].res);
            @(negedge clk);
            chk_a(vecs[i].name, vecs[i].e_stall, vecs[i].e_sel, vecs[i].e_flush,
                  vecs[i].e_jmp, vecs[i].e_state, vecs[i].e_cnt);
        end

        // Three-cycle load stall on the LOAD_STALL_CYC=3 instance.
        reset_pulse();
        @(posedge clk); #1;
        drive(0, 16'h0, 1, 3, 3, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk_b("l3_c1", 1, 0, 1, 16'h0, 2'd0, 16'd0);
        @(posedge clk); #1;
        drive(1, 16'h0099, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk_b("l3_c2", 1, 0, 1, 16'h0, 2'd1, 16'd1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk_b("l3_c3", 1, 0, 1, 16'h0, 2'd1, 16'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk_b("l3_done", 0, 0, 0, 16'h0, 2'd0, 16'd3);

        // Reset landing in the second LSTALL cycle.
        @(posedge clk); #1;
        drive(0, 16'h0, 1, 2, 0, 2, 0, 1, 0, 0);
        @(negedge clk);
        chk_b("l3r_c1", 1, 0, 1, 16'h0, 2'd0, 16'd3);
        @(posedge clk); #1;
        drive(1, 16'h0055, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_b("l3r_c2", 1, 0, 1, 16'h0, 2'd1, 16'd4);
        #1;
        reset = 1'b0;
        #1;
        chk_b("l3r_rst", 0, 0, 0, 16'h0, 2'd0, 16'd0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_b("l3r_after", 0, 0, 0, 16'h0, 2'd0, 16'd0);

        // Long halt: stall counter must saturate, not wrap.
        reset_pulse();
        @(posedge clk); #1;
        halt_req = 1'b1;
        @(posedge clk); #1;
        halt_req = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk_a("sat_halt", 1, 0, 1, 16'h0, 2'd3, 16'hFFFF);
        @(posedge clk); #1;
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        @(negedge clk);
        chk_a("sat_run", 0, 0, 0, 16'h0, 2'd0, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
